// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store handshake bundle between the core (master) and the data-memory
// responder (slave).
//   Request  : req_valid (M->S), req_ready (S->M), req_we, req_addr[31:0],
//              req_be[3:0], req_wdata[31:0] (M->S)
//   Response : rsp_valid (S->M), rsp_ready (M->S), rsp_rdata[31:0],
//              rsp_err (S->M)
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the core's data port. Accepts one request at a time,
// waits WAIT_CYCLES cycles, performs the access on the edge entering RESP and
// holds the response until the requester takes it.
//
// Ports:
//   clk      : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : dmem_responder_if.slave (request / response handshakes)
//
// Parameters:
//   DEPTH       : number of 32-bit words (power of two, 4..65536)
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//
// Optional feature macro: DMEM_RESPONDER_ERR_EN
//   Defined   : misaligned or out-of-range accesses flag rsp_err, do not write
//               and return zero data.
//   Undefined : low address bits ignored, addresses wrap, rsp_err tied to 0.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 32'sd0) ? 4'(WAIT_CYCLES - 32'sd1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;
  logic            w_enter_resp;

  // Captured request
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic            r_acc_err;

  // Registered outputs
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic [31:0]     r_mem [DEPTH];

  // Access operands seen on the edge that enters RESP
  logic            w_acc_we;
  logic [AW-1:0]   w_acc_idx;
  logic [3:0]      w_acc_be;
  logic [31:0]     w_acc_wdata;
  logic            w_acc_err;
  logic            w_req_err;
  logic            w_mem_wr;

`ifdef DMEM_RESPONDER_ERR_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH) * 32'd4;
  assign w_req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIMIT);
`else
  // Byte-offset and above-range address bits are don't-care without checking
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
  assign w_req_err     = 1'b0;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // Next-state, wait counter and access-strobe decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 32'sd0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // Return to IDLE only; a new request waits for the following cycle
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // live request is used from IDLE; otherwise the captured request is used.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_acc_we    = bus.req_we;
      w_acc_idx   = bus.req_addr[AW+1:2];
      w_acc_be    = bus.req_be;
      w_acc_wdata = bus.req_wdata;
      w_acc_err   = w_req_err;
    end else begin
      w_acc_we    = r_we;
      w_acc_idx   = r_idx;
      w_acc_be    = r_be;
      w_acc_wdata = r_wdata;
      w_acc_err   = r_acc_err;
    end
  end

  // Gated by reset_n so an edge seen while reset is held never writes
  assign w_mem_wr = w_enter_resp && w_acc_we && !w_acc_err && reset_n;

  // FSM state and wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_be      <= 4'd0;
      r_wdata   <= 32'd0;
      r_acc_err <= 1'b0;
    end else if (w_accept) begin
      r_we      <= bus.req_we;
      r_idx     <= bus.req_addr[AW+1:2];
      r_be      <= bus.req_be;
      r_wdata   <= bus.req_wdata;
      r_acc_err <= w_req_err;
    end
  end

  // Handshake outputs follow the next state so they are registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // Response data and error, loaded once on RESP entry and held until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_acc_err;
      r_rdata <= (w_acc_we || w_acc_err) ? 32'd0 : r_mem[w_acc_idx];
    end
  end

  // Byte-enabled RAM write; contents are not reset
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. One instance uses WAIT_CYCLES=2, a
// second uses WAIT_CYCLES=0 for the back-to-back timing case. Expected data
// comes from a word-array model updated with byte-enable arithmetic.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH  = 256;
  localparam int W      = 2;
  localparam int DEPTH0 = 64;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] model  [DEPTH];
  logic [31:0] model0 [DEPTH0];

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  dmem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input int depth);
`ifdef DMEM_RESPONDER_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(depth) * 32'd4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a, input int depth);
    return int'(a[31:2]) % depth;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One transaction on the WAIT_CYCLES=2 instance; called at a negedge with
  // the responder idle. stall = cycles rsp_ready is held low once rsp_valid rises.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int stall, output logic [31:0] rd);
    int          n;
    int          i;
    logic        e;
    logic [31:0] exp_rd;
    logic        er;
    e      = exp_err(addr, DEPTH);
    i      = widx(addr, DEPTH);
    exp_rd = (we || e) ? 32'd0 : model[i];
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    bus.rsp_ready = (stall == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(W + 1));
    check("rsp_valid", bus.rsp_valid, 1'b1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    check("rdata", rd, exp_rd);
    check("rsp_err", er, e);
    if (we && !e) model[i] = merge(model[i], wd, be);
    for (int s = 0; s < stall; s++) begin
      // A competing store while the response is pending must be ignored
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      bus.req_be    = 4'hF;
      bus.req_wdata = $urandom;
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1'b1);
      check("stall_rdata", bus.rsp_rdata, rd);
      check("stall_err", bus.rsp_err, er);
      check("stall_req_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", bus.rsp_valid, 1'b0);
    check("post_req_ready", bus.req_ready, 1'b1);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] old40;
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_be     = 4'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_be    = 4'd0;
    bus0.req_wdata = 32'd0;
    bus0.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", bus.rsp_err, 1'b0);
    check("rst_req_ready0", bus0.req_ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill RAM so every later load has a defined expectation
    for (int k = 0; k < DEPTH; k++) txn(1'b1, 32'(k) << 2, 4'hF, $urandom, 0, rd);

    // Store / load round trip
    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd);
    txn(1'b0, 32'h10, 4'h0, 32'd0, 0, rd);
    check("deadbeef", rd, 32'hDEADBEEF);

    // Byte enables
    txn(1'b1, 32'h20, 4'hF, 32'h11223344, 0, rd);
    txn(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, rd);
    txn(1'b0, 32'h20, 4'hF, 32'd0, 0, rd);
    check("byte_en", rd, 32'h11BB33DD);

    // Store with no enables leaves the word alone
    txn(1'b1, 32'h20, 4'h0, 32'h55555555, 0, rd);
    txn(1'b0, 32'h20, 4'h0, 32'd0, 0, rd);
    check("be_zero", rd, 32'h11BB33DD);

    // Backpressure on a load response
    txn(1'b0, 32'h20, 4'h0, 32'd0, 5, rd);
    check("bp_rdata", rd, 32'h11BB33DD);

    // Reset during WAIT of a store to 0x40
    old40 = model[16];
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_be    = 4'hF;
    bus.req_wdata = ~old40;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    check("mid_rst_err", bus.rsp_err, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h40, 4'h0, 32'd0, 0, rd);
    check("rst_store_dropped", rd, old40);

    // Misaligned store and out-of-range load
    txn(1'b1, 32'h13, 4'hF, 32'h0BADF00D, 0, rd);
    txn(1'b0, 32'h10, 4'h0, 32'd0, 0, rd);
`ifdef DMEM_RESPONDER_ERR_EN
    check("err_store_unchanged", rd, 32'hDEADBEEF);
    txn(1'b0, 32'(DEPTH) * 32'd4, 4'h0, 32'd0, 0, rd);
    check("err_load_zero", rd, 32'd0);
`else
    check("wrap_store", rd, 32'h0BADF00D);
    txn(1'b0, 32'(DEPTH) * 32'd4, 4'h0, 32'd0, 0, rd);
    check("wrap_load", rd, model[0]);
`endif

    // Randomized mix, including out-of-range and misaligned addresses
    for (int k = 0; k < 150; k++) begin
      txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH * 4 + 63)),
          4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), rd);
    end

    // Zero-wait instance: req_valid held high, back-to-back requests
    for (int k = 0; k < 32; k++) begin
      logic        we0;
      int          i0;
      logic [31:0] wd0;
      logic [3:0]  be0;
      we0 = (k < 16);
      i0  = we0 ? k : $urandom_range(0, 15);
      wd0 = $urandom;
      be0 = (k < 4) ? 4'hF : 4'($urandom_range(0, 15));
      if (k < 16 && k >= 4) be0 = 4'hF;
      check("w0_req_ready", bus0.req_ready, 1'b1);
      check("w0_idle_valid", bus0.rsp_valid, 1'b0);
      bus0.req_valid = 1'b1;
      bus0.req_we    = we0;
      bus0.req_addr  = 32'(i0) << 2;
      bus0.req_be    = be0;
      bus0.req_wdata = wd0;
      @(negedge clk);
      check("w0_rsp_valid", bus0.rsp_valid, 1'b1);
      check("w0_busy_ready", bus0.req_ready, 1'b0);
      check("w0_rdata", bus0.rsp_rdata, we0 ? 32'd0 : model0[i0]);
      check("w0_err", bus0.rsp_err, 1'b0);
      if (we0) model0[i0] = merge(model0[i0], wd0, be0);
      // Still valid during the handshake cycle: must not be taken
      bus0.req_we    = 1'b1;
      bus0.req_addr  = 32'($urandom_range(0, 15)) << 2;
      bus0.req_be    = 4'hF;
      bus0.req_wdata = $urandom;
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port. It is the memory-side end of the core's data access: it accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and then returns read data or write completion over a second valid/ready handshake. It holds a word-addressed RAM with byte-enable writes and stands in for the data memory when the core moves to a handshaked memory interface.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- WAIT_CYCLES, 2: wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_be  in  4  byte enables for stores; bit i enables wdata[8i+7:8i].
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errored accesses.
- rsp_err  out  1  access error flag, qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE). rsp_valid = (state == RESP).
- **Request acceptance.** A request is accepted on a cycle where req_valid && req_ready. On acceptance, the block registers we, addr, be and wdata.
  - WAIT_CYCLES > 0: go to WAIT and load the counter with WAIT_CYCLES-1.
  - WAIT_CYCLES == 0: go directly to RESP.
- **WAIT.** The counter decrements every cycle. When the counter is 0, go to RESP.
- **Entering RESP.** The access executes on the clock edge that enters RESP.
  - Store: write only the enabled bytes.
  - Load: register the full word into rsp_rdata. req_be is ignored for loads.
- **RESP.** rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready. After that handshake, go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake.
- **Word index:** req_addr[log2(DEPTH)+1:2].
- **Store with req_be = 0:** completes normally with no bytes modified.
- Request inputs are ignored outside IDLE.
- **Reset values:** state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0. RAM contents are not reset.
- **Reset mid-operation:** the transaction is abandoned. A store that has not yet reached RESP is not performed.

## Timing
- Request accepted at cycle T gives rsp_valid high from cycle T+1+WAIT_CYCLES.
- With rsp_ready held at 1, the minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Read data reflects all stores completed before the load's RESP entry.
- A load immediately after a store to the same word returns the new data.
- No combinational path from req_* to rsp_*, or from rsp_ready to req_ready.

## Configuration
- Macro DMEM_RESPONDER_ERR_EN compiles in access checking.
- **Defined:** rsp_err = 1 when req_addr[1:0] != 0 or req_addr >= DEPTH*4. An errored access:
  - does not write the RAM,
  - returns rsp_rdata = 0,
  - keeps the same latency and handshake as a normal access.
- **Undefined:**
  - req_addr[1:0] is ignored.
  - Addresses wrap modulo DEPTH*4.
  - rsp_err is tied to 0.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10. Required: rsp_valid first seen at T+3 for WAIT_CYCLES=2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte enables: word at 0x20 = 0x11223344; store 0xAABBCCDD with be=4'b0101; load 0x20. Required: 0x11BB33DD.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response. Required: rsp_valid and rsp_rdata stable throughout, req_ready=0, a second req_valid ignored. After rsp_ready=1, IDLE on the next cycle.
- WAIT_CYCLES=0 with back-to-back loads and rsp_ready=1. Required: rsp_valid at T+1, next acceptance at T+2.
- With DMEM_RESPONDER_ERR_EN defined:
  - store to 0x13: rsp_err=1, memory unchanged;
  - load from DEPTH*4: rsp_err=1, rdata=0.
  Without the macro: a load from DEPTH*4 returns the word at 0x0.
- Assert reset_n low during WAIT of a store to 0x40, then release and load 0x40. Required: outputs return to reset values immediately, and the old data at 0x40 is unchanged.
